// File: rtl/key_debounce_repeat.sv
// ---------------------------------------------------------------------------
// key_debounce_repeat
//
// Input stage for electric_clock. Each of the KEY_W raw, active-low push
// buttons is synchronised, debounced and turned into clean single-cycle
// press/release pulses, a debounced level and (optionally) auto-repeat
// pulses while the key stays held. Keys are handled fully independently.
//
// Optional feature macro: KEY_AUTO_REPEAT_EN
//   defined     : DOWN -> RPT after MCNT_HOLD held cycles, then a Key_Rpt
//                 pulse every MCNT_RPT held cycles.
//   not defined : no RPT state, no hold/repeat counters, Key_Rpt tied to 0.
//
// Ports
//   Clk         in   system clock
//   Reset_n     in   synchronous active-low reset
//   Key         in   [KEY_W] raw buttons, asynchronous, 0 = pressed
//   Key_Press   out  [KEY_W] one-cycle pulse per accepted press
//   Key_Release out  [KEY_W] one-cycle pulse per accepted release
//   Key_State   out  [KEY_W] debounced level, 1 = pressed
//   Key_Rpt     out  [KEY_W] one-cycle auto-repeat pulses while held
// ---------------------------------------------------------------------------
module key_debounce_repeat #(
  parameter int KEY_W     = 4,
  parameter int MCNT_DB   = 1_000_000,
  parameter int MCNT_HOLD = 50_000_000,
  parameter int MCNT_RPT  = 10_000_000
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [KEY_W-1:0] Key,
  output logic [KEY_W-1:0] Key_Press,
  output logic [KEY_W-1:0] Key_Release,
  output logic [KEY_W-1:0] Key_State,
  output logic [KEY_W-1:0] Key_Rpt
);

  // Elaboration-time guard on the legal parameter range.
  if (MCNT_DB < 2 || MCNT_HOLD < 2 || MCNT_RPT < 2) begin : g_bad_param
    $error("key_debounce_repeat: MCNT_DB/MCNT_HOLD/MCNT_RPT must be >= 2");
  end

  localparam int DB_W = $clog2(MCNT_DB + 1);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(MCNT_DB);
  localparam logic [DB_W-1:0] DB_ONE = DB_W'(1);

`ifdef KEY_AUTO_REPEAT_EN
  localparam int HOLD_W = $clog2(MCNT_HOLD + 1);
  localparam int RPT_W  = $clog2(MCNT_RPT + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MCNT_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
  // The pulse cycle itself is the MCNT_RPT-th held cycle of a repeat period,
  // so the pulse fires when the count of earlier cycles equals MCNT_RPT-1.
  localparam logic [RPT_W-1:0]  RPT_LAST = RPT_W'(MCNT_RPT - 1);
  localparam logic [RPT_W-1:0]  RPT_ONE  = RPT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESS_DB,
    ST_DOWN,
    ST_RPT,
    ST_REL_DB
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESS_DB,
    ST_DOWN,
    ST_REL_DB
  } state_t;
`endif

  // Two-flop synchroniser; reset value 1 means "released".
  logic [KEY_W-1:0] r_sync1;
  logic [KEY_W-1:0] r_sync2;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= Key;
      r_sync2 <= r_sync1;
    end
  end

`ifndef KEY_AUTO_REPEAT_EN
  assign Key_Rpt = '0;
`endif

  for (genvar gi = 0; gi < KEY_W; gi++) begin : g_key
    logic w_ks;
    assign w_ks = r_sync2[gi];

    state_t          r_state;
    state_t          w_state_nxt;
    // One debounce counter serves both PRESS_DB and REL_DB; the two states
    // are exclusive and each (re)loads it on entry.
    logic [DB_W-1:0] r_db_cnt;
    logic [DB_W-1:0] w_db_cnt_nxt;

    logic w_press_evt;
    logic w_rel_evt;
    logic r_press_evt;
    logic r_rel_evt;
    logic r_press;
    logic r_release;
    logic r_level;

`ifdef KEY_AUTO_REPEAT_EN
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [HOLD_W-1:0] w_hold_cnt_nxt;
    logic [RPT_W-1:0]  r_rpt_cnt;
    logic [RPT_W-1:0]  w_rpt_cnt_nxt;
    // Remembers whether REL_DB was entered from RPT so a release bounce
    // returns to the right held state.
    logic              r_from_rpt;
    logic              w_from_rpt_nxt;
    logic              w_rpt_evt;
    logic              r_rpt;
`endif

    always_comb begin
      w_state_nxt  = r_state;
      w_db_cnt_nxt = r_db_cnt;
      w_press_evt  = 1'b0;
      w_rel_evt    = 1'b0;
`ifdef KEY_AUTO_REPEAT_EN
      w_hold_cnt_nxt = r_hold_cnt;
      w_rpt_cnt_nxt  = r_rpt_cnt;
      w_from_rpt_nxt = r_from_rpt;
      w_rpt_evt      = 1'b0;
`endif
      unique case (r_state)
        ST_IDLE: begin
          if (!w_ks) begin
            w_state_nxt  = ST_PRESS_DB;
            w_db_cnt_nxt = DB_ONE;
          end
        end
        ST_PRESS_DB: begin
          if (w_ks) begin
            w_state_nxt  = ST_IDLE;
            w_db_cnt_nxt = '0;
          end else if (r_db_cnt == DB_MAX) begin
            w_state_nxt  = ST_DOWN;
            w_db_cnt_nxt = '0;
            w_press_evt  = 1'b1;
          end else begin
            w_db_cnt_nxt = r_db_cnt + DB_ONE;
          end
        end
        ST_DOWN: begin
          if (w_ks) begin
            w_state_nxt  = ST_REL_DB;
            w_db_cnt_nxt = DB_ONE;
`ifdef KEY_AUTO_REPEAT_EN
            w_from_rpt_nxt = 1'b0;
          end else if (r_hold_cnt == HOLD_MAX) begin
            w_state_nxt   = ST_RPT;
            w_rpt_cnt_nxt = '0;
            w_rpt_evt     = 1'b1;
          end else begin
            w_hold_cnt_nxt = r_hold_cnt + HOLD_ONE;
`endif
          end
        end
`ifdef KEY_AUTO_REPEAT_EN
        ST_RPT: begin
          if (w_ks) begin
            w_state_nxt    = ST_REL_DB;
            w_db_cnt_nxt   = DB_ONE;
            w_from_rpt_nxt = 1'b1;
          end else if (r_rpt_cnt == RPT_LAST) begin
            w_rpt_cnt_nxt = '0;
            w_rpt_evt     = 1'b1;
          end else begin
            w_rpt_cnt_nxt = r_rpt_cnt + RPT_ONE;
          end
        end
`endif
        ST_REL_DB: begin
          if (!w_ks) begin
            // Release bounce: resume the held state with its counter intact.
`ifdef KEY_AUTO_REPEAT_EN
            w_state_nxt  = r_from_rpt ? ST_RPT : ST_DOWN;
`else
            w_state_nxt  = ST_DOWN;
`endif
            w_db_cnt_nxt = '0;
          end else if (r_db_cnt == DB_MAX) begin
            w_state_nxt  = ST_IDLE;
            w_db_cnt_nxt = '0;
            w_rel_evt    = 1'b1;
`ifdef KEY_AUTO_REPEAT_EN
            w_hold_cnt_nxt = '0;
            w_rpt_cnt_nxt  = '0;
            w_from_rpt_nxt = 1'b0;
`endif
          end else begin
            w_db_cnt_nxt = r_db_cnt + DB_ONE;
          end
        end
        default: begin
          w_state_nxt  = ST_IDLE;
          w_db_cnt_nxt = '0;
        end
      endcase
    end

    always_ff @(posedge Clk) begin
      if (!Reset_n) begin
        r_state     <= ST_IDLE;
        r_db_cnt    <= '0;
        r_press_evt <= 1'b0;
        r_rel_evt   <= 1'b0;
        r_press     <= 1'b0;
        r_release   <= 1'b0;
        r_level     <= 1'b0;
`ifdef KEY_AUTO_REPEAT_EN
        r_hold_cnt  <= '0;
        r_rpt_cnt   <= '0;
        r_from_rpt  <= 1'b0;
        r_rpt       <= 1'b0;
`endif
      end else begin
        r_state     <= w_state_nxt;
        r_db_cnt    <= w_db_cnt_nxt;
        // Press/release leave the FSM one cycle after the state change and
        // are then registered once more at the output.
        r_press_evt <= w_press_evt;
        r_rel_evt   <= w_rel_evt;
        r_press     <= r_press_evt;
        r_release   <= r_rel_evt;
        if (r_press_evt) begin
          r_level <= 1'b1;
        end else if (r_rel_evt) begin
          r_level <= 1'b0;
        end
`ifdef KEY_AUTO_REPEAT_EN
        r_hold_cnt  <= w_hold_cnt_nxt;
        r_rpt_cnt   <= w_rpt_cnt_nxt;
        r_from_rpt  <= w_from_rpt_nxt;
        // Repeat pulses are registered on the deciding edge so none can
        // slip out once the key has been seen released.
        r_rpt       <= w_rpt_evt;
`endif
      end
    end

    assign Key_Press[gi]   = r_press;
    assign Key_Release[gi] = r_release;
    assign Key_State[gi]   = r_level;
`ifdef KEY_AUTO_REPEAT_EN
    assign Key_Rpt[gi]     = r_rpt;
`endif
  end

endmodule
